// File: rtl/modos.sv
// Status-mode core of the virtual-pet game: need levels, decay, action windows, LEDs.
// Optional input debouncer enabled by defining MODOS_DEBOUNCE_EN.
module modos #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TEST_DIV      = 10,
    parameter int DECAY_SEC     = 10,
    parameter int HOLD_SEC      = 5
`ifdef MODOS_DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES    = 4
`endif
) (
    input  logic       clk,
    input  logic       Bot_Reset,
    input  logic       Bot_Test,
    input  logic       Bot_Energia,
    input  logic       Bot_Medicina,
    input  logic       Entrada_Descanso,
    input  logic       Entrada_Animo,
    output logic [0:1] LED_Animo,
    output logic [0:1] LED_Energia,
    output logic [0:1] LED_Descanso,
    output logic [0:1] LED_Medicina,
    output logic       senal_5segMedicina,
    output logic       senal_5segEnergia
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SW = (DECAY_SEC > 1) ? $clog2(DECAY_SEC) : 1;
    localparam int HW = (HOLD_SEC > 1) ? $clog2(HOLD_SEC) : 1;
    localparam logic [PW-1:0] LIM_NORM  = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] LIM_TEST  = PW'(TICKS_PER_SEC / TEST_DIV - 1);
    localparam logic [SW-1:0] SEC_LAST  = SW'(DECAY_SEC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_SEC - 1);

    typedef enum logic {
        WIN_IDLE   = 1'b0,
        WIN_ACTIVE = 1'b1
    } win_t;

    // sync bit map: 4 test, 3 energia, 2 medicina, 1 descanso, 0 animo
    logic [4:0] sync1;
    logic [4:0] sync2;

    always_ff @(posedge clk or negedge Bot_Reset) begin
        if (!Bot_Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {Bot_Test, Bot_Energia, Bot_Medicina, Entrada_Descanso, Entrada_Animo};
            sync2 <= sync1;
        end
    end

    logic energia_c;
    logic medicina_c;
    logic animo_c;
    logic test_s;
    logic rest_s;

    assign test_s = sync2[4];
    assign rest_s = sync2[1];

`ifdef MODOS_DEBOUNCE_EN
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [2:0]    deb_in;
    logic [2:0]    deb_q;
    logic [DW-1:0] deb_cnt [3];

    assign deb_in = {sync2[3], sync2[2], sync2[0]};

    always_ff @(posedge clk or negedge Bot_Reset) begin
        if (!Bot_Reset) begin
            deb_q <= '0;
            for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (deb_in[i] == deb_q[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_q[i]   <= deb_in[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign energia_c  = deb_q[2];
    assign medicina_c = deb_q[1];
    assign animo_c    = deb_q[0];
`else
    assign energia_c  = sync2[3];
    assign medicina_c = sync2[2];
    assign animo_c    = sync2[0];
`endif

    logic energia_d;
    logic medicina_d;
    logic animo_d;
    logic test_d;
    logic [PW-1:0] pre_cnt;
    logic [SW-1:0] sec_cnt;
    logic test_chg;
    logic tick;
    logic decay;
    logic animo_rise;
    logic [1:0] win_rise;

    assign test_chg   = test_s ^ test_d;
    assign tick       = !test_chg && (pre_cnt == (test_s ? LIM_TEST : LIM_NORM));
    assign decay      = tick && (sec_cnt == SEC_LAST);
    assign animo_rise = animo_c & ~animo_d;
    assign win_rise   = {medicina_c & ~medicina_d, energia_c & ~energia_d};

    always_ff @(posedge clk or negedge Bot_Reset) begin
        if (!Bot_Reset) begin
            energia_d  <= 1'b0;
            medicina_d <= 1'b0;
            animo_d    <= 1'b0;
            test_d     <= 1'b0;
            pre_cnt    <= '0;
            sec_cnt    <= '0;
        end else begin
            energia_d  <= energia_c;
            medicina_d <= medicina_c;
            animo_d    <= animo_c;
            test_d     <= test_s;
            if (test_chg || tick) pre_cnt <= '0;
            else                  pre_cnt <= pre_cnt + 1'b1;
            if (tick) sec_cnt <= (sec_cnt == SEC_LAST) ? '0 : sec_cnt + 1'b1;
        end
    end

    // window index 0 = Energia, 1 = Medicina
    win_t          win_q  [2];
    win_t          win_n  [2];
    logic [HW-1:0] hold_q [2];
    logic [HW-1:0] hold_n [2];
    logic [1:0]    win_done;

    always_ff @(posedge clk or negedge Bot_Reset) begin
        if (!Bot_Reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                win_q[i]  <= WIN_IDLE;
                hold_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                win_q[i]  <= win_n[i];
                hold_q[i] <= hold_n[i];
            end
        end
    end

    always_comb begin
        win_done = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            win_n[i]  = win_q[i];
            hold_n[i] = hold_q[i];
            if (win_q[i] == WIN_IDLE) begin
                if (win_rise[i]) begin
                    win_n[i]  = WIN_ACTIVE;
                    hold_n[i] = '0;
                end
            end else if (tick) begin
                if (hold_q[i] == HOLD_LAST) begin
                    win_n[i]    = WIN_IDLE;
                    win_done[i] = 1'b1;
                end else begin
                    hold_n[i] = hold_q[i] + 1'b1;
                end
            end
        end
    end

    assign senal_5segEnergia  = (win_q[0] == WIN_ACTIVE);
    assign senal_5segMedicina = (win_q[1] == WIN_ACTIVE);

    // simultaneous increment and decrement cancel out
    function automatic logic [1:0] step_level(input logic [1:0] lvl, input logic inc,
                                              input logic dec);
        logic [1:0] r;
        r = lvl;
        if (inc && !dec && (lvl != 2'b11))      r = lvl + 2'd1;
        else if (dec && !inc && (lvl != 2'b00)) r = lvl - 2'd1;
        return r;
    endfunction

    logic [1:0] lvl_energia;
    logic [1:0] lvl_medicina;
    logic [1:0] lvl_descanso;
    logic [1:0] lvl_animo;

    always_ff @(posedge clk or negedge Bot_Reset) begin
        if (!Bot_Reset) begin
            lvl_energia  <= '1;
            lvl_medicina <= '1;
            lvl_descanso <= '1;
            lvl_animo    <= '1;
            LED_Energia  <= '1;
            LED_Medicina <= '1;
            LED_Descanso <= '1;
            LED_Animo    <= '1;
        end else begin
            lvl_energia  <= step_level(lvl_energia,  win_done[0], decay);
            lvl_medicina <= step_level(lvl_medicina, win_done[1], decay);
            lvl_descanso <= step_level(lvl_descanso, tick && rest_s, decay && !rest_s);
            lvl_animo    <= step_level(lvl_animo,    animo_rise, decay);
            LED_Energia  <= lvl_energia;
            LED_Medicina <= lvl_medicina;
            LED_Descanso <= lvl_descanso;
            LED_Animo    <= lvl_animo;
        end
    end

endmodule

// File: tb/tb_modos.sv
// Self-checking bench for modos: directed scenarios plus randomized stimulus
// checked every cycle against a behavioural model of the game rules.
module tb_modos;

    localparam int TPS      = 4;
    localparam int TDIV     = 2;
    localparam int DECAY    = 3;
    localparam int HOLD     = 5;

    logic       clk = 1'b0;
    logic       Bot_Reset = 1'b0;
    logic       Bot_Test = 1'b0;
    logic       Bot_Energia = 1'b0;
    logic       Bot_Medicina = 1'b0;
    logic       Entrada_Descanso = 1'b0;
    logic       Entrada_Animo = 1'b0;
    logic [0:1] LED_Animo;
    logic [0:1] LED_Energia;
    logic [0:1] LED_Descanso;
    logic [0:1] LED_Medicina;
    logic       senal_5segMedicina;
    logic       senal_5segEnergia;

    int n_tests = 0;
    int n_fail  = 0;

    modos #(
        .TICKS_PER_SEC(TPS),
        .TEST_DIV(TDIV),
        .DECAY_SEC(DECAY),
        .HOLD_SEC(HOLD)
    ) dut (
        .clk(clk),
        .Bot_Reset(Bot_Reset),
        .Bot_Test(Bot_Test),
        .Bot_Energia(Bot_Energia),
        .Bot_Medicina(Bot_Medicina),
        .Entrada_Descanso(Entrada_Descanso),
        .Entrada_Animo(Entrada_Animo),
        .LED_Animo(LED_Animo),
        .LED_Energia(LED_Energia),
        .LED_Descanso(LED_Descanso),
        .LED_Medicina(LED_Medicina),
        .senal_5segMedicina(senal_5segMedicina),
        .senal_5segEnergia(senal_5segEnergia)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: inputs reach the core two clocks late; a window is a
    // count of remaining seconds; levels move by (credit - decay) clipped to 0..3.
    int m_lvl_e = 3, m_lvl_m = 3, m_lvl_d = 3, m_lvl_a = 3;
    int m_led_e = 3, m_led_m = 3, m_led_d = 3, m_led_a = 3;
    int m_win_e = 0, m_win_m = 0;
    int m_pre = 0, m_sec = 0;
    bit [4:0] m_s1 = '0, m_s2 = '0, m_prev = '0;

    function automatic int clip(input int v);
        return (v < 0) ? 0 : ((v > 3) ? 3 : v);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge Bot_Reset);
            if (!Bot_Reset) begin
                m_lvl_e = 3; m_lvl_m = 3; m_lvl_d = 3; m_lvl_a = 3;
                m_led_e = 3; m_led_m = 3; m_led_d = 3; m_led_a = 3;
                m_win_e = 0; m_win_m = 0; m_pre = 0; m_sec = 0;
                m_s1 = '0; m_s2 = '0; m_prev = '0;
            end else begin
                int lim, t_chg, tick, decay, r_e, r_m, r_a, d_e, d_m, rest;
                lim   = m_s2[4] ? TPS / TDIV : TPS;
                t_chg = int'(m_s2[4] != m_prev[4]);
                tick  = int'(t_chg == 0 && m_pre == lim - 1);
                decay = int'(tick != 0 && m_sec == DECAY - 1);
                r_e   = int'(m_s2[3] && !m_prev[3]);
                r_m   = int'(m_s2[2] && !m_prev[2]);
                r_a   = int'(m_s2[0] && !m_prev[0]);
                rest  = int'(m_s2[1]);
                d_e   = int'(m_win_e == 1 && tick != 0);
                d_m   = int'(m_win_m == 1 && tick != 0);
                m_led_e = m_lvl_e; m_led_m = m_lvl_m; m_led_d = m_lvl_d; m_led_a = m_lvl_a;
                m_lvl_e = clip(m_lvl_e + d_e - decay);
                m_lvl_m = clip(m_lvl_m + d_m - decay);
                m_lvl_d = clip(m_lvl_d + tick * rest - decay * (1 - rest));
                m_lvl_a = clip(m_lvl_a + r_a - decay);
                if (m_win_e == 0) begin
                    if (r_e != 0) m_win_e = HOLD;
                end else if (tick != 0) m_win_e--;
                if (m_win_m == 0) begin
                    if (r_m != 0) m_win_m = HOLD;
                end else if (tick != 0) m_win_m--;
                if (tick != 0) m_sec = (m_sec == DECAY - 1) ? 0 : m_sec + 1;
                m_pre  = (t_chg != 0 || tick != 0) ? 0 : m_pre + 1;
                m_prev = m_s2;
                m_s2   = m_s1;
                m_s1   = {Bot_Test, Bot_Energia, Bot_Medicina, Entrada_Descanso, Entrada_Animo};
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            check("led_energia",  int'(LED_Energia),  m_led_e);
            check("led_medicina", int'(LED_Medicina), m_led_m);
            check("led_descanso", int'(LED_Descanso), m_led_d);
            check("led_animo",    int'(LED_Animo),    m_led_a);
            check("flag_energia", int'(senal_5segEnergia),  int'(m_win_e != 0));
            check("flag_medicina", int'(senal_5segMedicina), int'(m_win_m != 0));
        end
    end

    task automatic measure_feed(output int len);
        int waited;
        len = 0;
        waited = 0;
        Bot_Energia = 1'b1;
        while (!senal_5segEnergia && waited < 8) begin
            @(negedge clk); #1;
            waited++;
            if (waited == 2) Bot_Energia = 1'b0;
        end
        Bot_Energia = 1'b0;
        check("feed_start", int'(senal_5segEnergia), 1);
        for (int i = 0; i < 40 && senal_5segEnergia; i++) begin
            if (i == 8)  Bot_Energia = 1'b1;
            if (i == 10) Bot_Energia = 1'b0;
            @(negedge clk); #1;
            len++;
        end
        Bot_Energia = 1'b0;
    endtask

    initial begin
        int len;
        int waited;

        repeat (3) @(negedge clk);
        #1;
        check("rst_led_energia",  int'(LED_Energia),  3);
        check("rst_led_medicina", int'(LED_Medicina), 3);
        check("rst_led_descanso", int'(LED_Descanso), 3);
        check("rst_led_animo",    int'(LED_Animo),    3);
        check("rst_flag_energia", int'(senal_5segEnergia),  0);
        check("rst_flag_medicina", int'(senal_5segMedicina), 0);

        @(negedge clk);
        Bot_Reset = 1'b1;
        repeat (11) @(negedge clk);
        #1;
        check("pre_decay_energia", int'(LED_Energia), 3);
        repeat (2) @(negedge clk);
        #1;
        check("decay_energia",  int'(LED_Energia),  2);
        check("decay_medicina", int'(LED_Medicina), 2);
        check("decay_descanso", int'(LED_Descanso), 2);
        check("decay_animo",    int'(LED_Animo),    2);

        measure_feed(len);
        check("feed_len_normal", int'(len >= 17 && len <= 20), 1);

        Entrada_Descanso = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("rest_saturate", int'(LED_Descanso), 3);
        Entrada_Descanso = 1'b0;

        Bot_Test = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        measure_feed(len);
        check("feed_len_test", int'(len >= 9 && len <= 10), 1);
        Bot_Test = 1'b0;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) Entrada_Animo = ~Entrada_Animo;
            @(negedge clk);
        end
        Entrada_Animo = 1'b0;
        repeat (4) @(negedge clk);

        Bot_Medicina = 1'b1;
        waited = 0;
        #1;
        while (!senal_5segMedicina && waited < 8) begin
            @(negedge clk); #1;
            waited++;
            if (waited == 2) Bot_Medicina = 1'b0;
        end
        Bot_Medicina = 1'b0;
        check("med_start", int'(senal_5segMedicina), 1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        Bot_Reset = 1'b0;
        #1;
        check("abort_flag_medicina", int'(senal_5segMedicina), 0);
        check("abort_led_medicina",  int'(LED_Medicina), 3);
        @(negedge clk);
        Bot_Reset = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0)  Bot_Energia      = ~Bot_Energia;
            if ($urandom_range(0, 11) == 0)  Bot_Medicina     = ~Bot_Medicina;
            if ($urandom_range(0, 5) == 0)   Entrada_Animo    = ~Entrada_Animo;
            if ($urandom_range(0, 49) == 0)  Entrada_Descanso = ~Entrada_Descanso;
            if ($urandom_range(0, 299) == 0) Bot_Test         = ~Bot_Test;
            Bot_Reset = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        Bot_Reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
